scan_display_ctrl: RTL and testbench
====================================

# scan_display_ctrl

Time-multiplexed controller for the dual-digit compare display. It latches a high/low nibble pair on a load strobe and schedules one shared SevenSeg decoder between two digit positions on a common segment bus. It drives the digit enables and the comparison decimal point per slot, and blinks both points when the values are equal. It sits between the switch/input logic and the board's multiplexed 7-segment pins.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot (≥2).
- BLINK_SLOTS, 256: completed slots per blink-phase toggle (≥1).
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- load  input  1  capture strobe for din_high/din_low (single-cycle or held; sampled every cycle).
- din_high  input  4  high-digit value, unsigned.
- din_low  input  4  low-digit value, unsigned.
- seg  output  7  decoded segments of the currently enabled digit (SevenSeg encoding).
- dp  output  1  decimal point of the currently enabled digit.
- dig_en  output  2  one-hot digit enable; bit1 = high digit, bit0 = low digit.

## Operation
- Registers: act_hi/act_lo (displayed pair), pend_hi/pend_lo + pend_valid (shadow pair), timer [0..SCAN_DIV-1], blink_cnt [0..BLINK_SLOTS-1], blink_ph, state.
- States:
  - BLANK: reset state; dig_en=00, seg=0, dp=0.
  - SCAN_HI: dig_en=10, seg=dec(act_hi).
  - SCAN_LO: dig_en=01, seg=dec(act_lo).
- BLANK → SCAN_HI on first load. act ← din and timer ← 0 on the same edge. blink_ph ← 1.
- In SCAN_*: timer increments each cycle. At terminal count (timer==SCAN_DIV-1), timer ← 0 and the state toggles HI↔LO. Terminal count is the slot boundary.
- Load in SCAN_*: pend ← din, pend_valid ← 1. A later load before the boundary overwrites pend (last wins). The displayed pair never changes mid-slot.
- At the slot boundary, act is updated with priority: load this cycle → din; else pend_valid → pend; else hold. pend_valid ← 0. Any act update sets blink_ph ← 1 and blink_cnt ← 0.
- Blink: each boundary without an act update increments blink_cnt. At wrap, blink_ph toggles.
- dp, all comparisons unsigned 4-bit:
  - act_hi > act_lo: dp=1 in SCAN_HI only.
  - act_hi < act_lo: dp=1 in SCAN_LO only.
  - equal: dp=blink_ph in both slots.
- No return to BLANK except by reset.

## Timing
- seg, dp and dig_en are combinational decodes of registered state only; there is no input-to-output combinational path.
- Reset (rst_n=0 at an edge) forces BLANK. It also clears all counters, act, pend, pend_valid and blink_ph to 0. Outputs read 00/0/0 from the following cycle.
- Reset mid-scan or with load asserted in the same cycle: reset wins and the load is dropped.
- First load at edge t: dig_en=10 from cycle t+1. The first boundary is SCAN_DIV cycles later.
- A load in SCAN_* at cycle t is visible at the next boundary edge at or after t. Worst-case latency is SCAN_DIV cycles.
- Slot length is exactly SCAN_DIV cycles. Full HI+LO frame is 2·SCAN_DIV.
- dig_en is never 11. It changes only at a boundary edge.

## Structure
- Shared package lab8_pkg:
  - state enum {BLANK, SCAN_HI, SCAN_LO}.
  - dig_en constants DIG_NONE=2'b00, DIG_HI=2'b10, DIG_LO=2'b01.
- One sub-module: the existing SevenSeg decoder, instantiated once. Its input is muxed act_hi/act_lo by state.
- Timer and blink counter widths are $clog2 of their parameters.

## Test plan (SCAN_DIV=4, BLINK_SLOTS=2)
- Reset held 3 cycles with load=1 and din=9/3 → dig_en=00, seg=0 and dp=0 throughout and one cycle after release.
- Load hi=9, lo=3 from BLANK → dig_en=10 and seg=dec(9) with dp=1 for 4 cycles, then dig_en=01 and seg=dec(3) with dp=0 for 4 cycles; repeats.
- Mid-slot load 2/7, then 5/5 two cycles later → no change until the boundary. Then act=5/5 (last wins), and dp=1 in both slots for 2 slots, then 0 for 2 slots, alternating.
- Load asserted exactly at terminal count with 1/8 → the next slot shows dec(1) or dec(8) as appropriate for its digit. dp=1 only in SCAN_LO.
- Reset asserted mid-SCAN_LO with pend_valid=1 → BLANK next cycle and the pending pair is discarded. A subsequent load restarts at SCAN_HI with timer=0.

Source files
------------

// File: rtl/lab8_pkg.sv
// Shared types for the dual-digit compare display.
// Holds the scan FSM states, digit-enable codes and the slot dp rule.
package lab8_pkg;

   typedef enum logic [1:0] {
      BLANK   = 2'd0,
      SCAN_HI = 2'd1,
      SCAN_LO = 2'd2
   } state_t;

   localparam logic [1:0] DIG_NONE = 2'b00;
   localparam logic [1:0] DIG_HI   = 2'b10;
   localparam logic [1:0] DIG_LO   = 2'b01;

   // The point marks the larger digit; equal values blink both points.
   function automatic logic slot_dp(
      input state_t     st,
      input logic [3:0] hi,
      input logic [3:0] lo,
      input logic       ph
   );
      logic r;
      r = 1'b0;
      if (st == BLANK)
         r = 1'b0;
      else if (hi > lo)
         r = (st == SCAN_HI);
      else if (hi < lo)
         r = (st == SCAN_LO);
      else
         r = ph;
      return r;
   endfunction

endpackage

// File: rtl/scan_display_ctrl_seg.sv
// SevenSeg decoder: hex nibble to active-high segments {g,f,e,d,c,b,a}.
// Ports: val (4-bit nibble in), seg (7 segment lines out).
module scan_display_ctrl_seg (
   input  logic [3:0] val,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h00;
      case (val)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end

endmodule

// File: rtl/scan_display_ctrl.sv
// Two-digit multiplexed compare display: latches a hi/lo nibble pair and
// scans it through one shared decoder. Ports: clk, rst_n (sync, low),
// load/din_high/din_low (capture), seg/dp/dig_en (display pins).
module scan_display_ctrl
   import lab8_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int BLINK_SLOTS = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] din_high,
   input  logic [3:0] din_low,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] dig_en
);

   localparam int TW = $clog2(SCAN_DIV);
   // A one-slot blink period still needs a one-bit counter register.
   localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_SLOTS - 1);

   state_t state;
   state_t state_nx;

   logic [3:0]    act_hi;
   logic [3:0]    act_lo;
   logic [3:0]    pend_hi;
   logic [3:0]    pend_lo;
   logic          pend_valid;
   logic [TW-1:0] timer;
   logic [BW-1:0] blink_cnt;
   logic          blink_ph;

   logic          boundary;
   logic          act_upd;
   logic [3:0]    act_nx_hi;
   logic [3:0]    act_nx_lo;
   logic [3:0]    dec_in;
   logic [6:0]    dec_seg;

   assign boundary = (state != BLANK) && (timer == T_LAST);

   // A load on the boundary edge beats an older pending pair.
   always_comb begin
      act_upd   = 1'b0;
      act_nx_hi = act_hi;
      act_nx_lo = act_lo;
      if (boundary) begin
         if (load) begin
            act_upd   = 1'b1;
            act_nx_hi = din_high;
            act_nx_lo = din_low;
         end else if (pend_valid) begin
            act_upd   = 1'b1;
            act_nx_hi = pend_hi;
            act_nx_lo = pend_lo;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= BLANK;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         BLANK:   if (load) state_nx = SCAN_HI;
         SCAN_HI: if (boundary) state_nx = SCAN_LO;
         SCAN_LO: if (boundary) state_nx = SCAN_HI;
         default: state_nx = BLANK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         act_hi     <= 4'd0;
         act_lo     <= 4'd0;
         pend_hi    <= 4'd0;
         pend_lo    <= 4'd0;
         pend_valid <= 1'b0;
         timer      <= '0;
         blink_cnt  <= '0;
         blink_ph   <= 1'b0;
      end else if (state == BLANK) begin
         if (load) begin
            act_hi    <= din_high;
            act_lo    <= din_low;
            timer     <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
         end
      end else begin
         timer <= boundary ? '0 : timer + 1'b1;
         if (boundary) begin
            pend_valid <= 1'b0;
            act_hi     <= act_nx_hi;
            act_lo     <= act_nx_lo;
            if (act_upd) begin
               blink_cnt <= '0;
               blink_ph  <= 1'b1;
            end else if (blink_cnt == B_LAST) begin
               blink_cnt <= '0;
               blink_ph  <= ~blink_ph;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end else if (load) begin
            pend_hi    <= din_high;
            pend_lo    <= din_low;
            pend_valid <= 1'b1;
         end
      end
   end

   assign dec_in = (state == SCAN_LO) ? act_lo : act_hi;

   scan_display_ctrl_seg u_seg (
      .val (dec_in),
      .seg (dec_seg)
   );

   always_comb begin
      dig_en = DIG_NONE;
      seg    = 7'h00;
      unique case (state)
         SCAN_HI: begin
            dig_en = DIG_HI;
            seg    = dec_seg;
         end
         SCAN_LO: begin
            dig_en = DIG_LO;
            seg    = dec_seg;
         end
         default: begin
            dig_en = DIG_NONE;
            seg    = 7'h00;
         end
      endcase
      dp = slot_dp(state, act_hi, act_lo, blink_ph);
   end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Randomized and directed bench for scan_display_ctrl against a
// slot-counting reference model (SCAN_DIV=4, BLINK_SLOTS=2).
module tb_scan_display_ctrl;

   localparam int SD = 4;
   localparam int BS = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0;
   logic [3:0] din_high = 4'd0;
   logic [3:0] din_low = 4'd0;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] dig_en;

   int total = 0;
   int bad = 0;

   scan_display_ctrl #(.SCAN_DIV(SD), .BLINK_SLOTS(BS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .din_high (din_high),
      .din_low  (din_low),
      .seg      (seg),
      .dp       (dp),
      .dig_en   (dig_en)
   );

   always #5 clk = ~clk;

   logic [6:0] tbl [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                              7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                              7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model: elapsed cycles since start, slots since last update.
   bit         m_on;
   int         m_cyc;
   int         m_since;
   logic [3:0] m_hi, m_lo, m_phi, m_plo;
   bit         m_pv;
   logic [6:0] e_seg;
   logic       e_dp;
   logic [1:0] e_dig;

   function automatic void model_edge(input logic r, input logic l,
                                      input logic [3:0] h,
                                      input logic [3:0] lo);
      bit bnd;
      bit hs;
      bit ph;
      if (!r) begin
         m_on = 0; m_cyc = 0; m_since = 0; m_pv = 0;
         m_hi = 0; m_lo = 0;
      end else if (!m_on) begin
         if (l) begin
            m_on = 1; m_cyc = 0; m_since = 0; m_pv = 0;
            m_hi = h; m_lo = lo;
         end
      end else begin
         bnd = ((m_cyc + 1) % SD) == 0;
         m_cyc++;
         if (bnd) begin
            if (l) begin
               m_hi = h; m_lo = lo; m_since = 0;
            end else if (m_pv) begin
               m_hi = m_phi; m_lo = m_plo; m_since = 0;
            end else begin
               m_since++;
            end
            m_pv = 0;
         end else if (l) begin
            m_phi = h; m_plo = lo; m_pv = 1;
         end
      end
      if (!m_on) begin
         e_seg = 7'h00; e_dp = 1'b0; e_dig = 2'b00;
      end else begin
         hs = ((m_cyc / SD) % 2) == 0;
         ph = ((m_since / BS) % 2) == 0;
         e_dig = hs ? 2'b10 : 2'b01;
         e_seg = tbl[hs ? m_hi : m_lo];
         if (m_hi > m_lo) e_dp = hs;
         else if (m_hi < m_lo) e_dp = !hs;
         else e_dp = ph;
      end
   endfunction

   task automatic step(input logic r, input logic l,
                       input logic [3:0] h, input logic [3:0] lo);
      @(negedge clk);
      rst_n = r; load = l; din_high = h; din_low = lo;
      @(posedge clk);
      model_edge(r, l, h, lo);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) step(1'b0, 1'b1, 4'd9, 4'd3);
         else step(1'b1, 1'b0, 4'd9, 4'd3);
         total++;
         if ({dig_en, seg, dp} !== 10'b0) begin
            bad++;
            $display("FAIL reset i=%0d dig/seg/dp got %b/%h/%b want 00/00/0",
                     i, dig_en, seg, dp);
         end
      end
   endtask

   task automatic test_basic;
      step(1'b1, 1'b1, 4'd9, 4'd3);
      total++;
      if (dig_en !== 2'b10 || seg !== 7'h6F || dp !== 1'b1) begin
         bad++;
         $display("FAIL first_load got %b/%h/%b want 10/6f/1",
                  dig_en, seg, dp);
      end
      for (int i = 0; i < 19; i++) begin
         step(1'b1, 1'b0, 4'd0, 4'd0);
         total++;
         if ({dig_en, seg, dp} !== {e_dig, e_seg, e_dp}) begin
            bad++;
            $display("FAIL basic i=%0d got %b/%h/%b want %b/%h/%b",
                     i, dig_en, seg, dp, e_dig, e_seg, e_dp);
         end
      end
   endtask

   task automatic test_last_wins;
      for (int i = 0; i < SD && (m_cyc % SD) != 0; i++)
         step(1'b1, 1'b0, 4'd0, 4'd0);
      step(1'b1, 1'b1, 4'd2, 4'd7);
      step(1'b1, 1'b0, 4'd0, 4'd0);
      step(1'b1, 1'b1, 4'd5, 4'd5);
      total++;
      if ({dig_en, seg, dp} !== {e_dig, e_seg, e_dp}) begin
         bad++;
         $display("FAIL midslot_hold got %b/%h/%b want %b/%h/%b",
                  dig_en, seg, dp, e_dig, e_seg, e_dp);
      end
      step(1'b1, 1'b0, 4'd0, 4'd0);
      total++;
      if (seg !== 7'h6D || dp !== 1'b1) begin
         bad++;
         $display("FAIL last_wins seg/dp got %h/%b want 6d/1", seg, dp);
      end
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 1'b0, 4'd0, 4'd0);
         total++;
         if ({dig_en, seg, dp} !== {e_dig, e_seg, e_dp}) begin
            bad++;
            $display("FAIL blink i=%0d got %b/%h/%b want %b/%h/%b",
                     i, dig_en, seg, dp, e_dig, e_seg, e_dp);
         end
      end
   endtask

   task automatic test_tc_load;
      for (int i = 0; i < SD && ((m_cyc + 1) % SD) != 0; i++)
         step(1'b1, 1'b0, 4'd0, 4'd0);
      step(1'b1, 1'b1, 4'd1, 4'd8);
      for (int i = 0; i < 9; i++) begin
         total++;
         if ({dig_en, seg, dp} !== {e_dig, e_seg, e_dp}) begin
            bad++;
            $display("FAIL tc_load i=%0d got %b/%h/%b want %b/%h/%b",
                     i, dig_en, seg, dp, e_dig, e_seg, e_dp);
         end
         step(1'b1, 1'b0, 4'd0, 4'd0);
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 2 * SD && (((m_cyc / SD) % 2) == 0 ||
           (m_cyc % SD) != 0); i++)
         step(1'b1, 1'b0, 4'd0, 4'd0);
      step(1'b1, 1'b1, 4'd4, 4'd6);
      step(1'b0, 1'b0, 4'd0, 4'd0);
      total++;
      if ({dig_en, seg, dp} !== 10'b0) begin
         bad++;
         $display("FAIL reset_mid got %b/%h/%b want 00/00/0",
                  dig_en, seg, dp);
      end
      step(1'b1, 1'b0, 4'd0, 4'd0);
      step(1'b1, 1'b1, 4'd3, 4'd2);
      total++;
      if (dig_en !== 2'b10 || seg !== 7'h4F || dp !== 1'b1) begin
         bad++;
         $display("FAIL restart got %b/%h/%b want 10/4f/1",
                  dig_en, seg, dp);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 4'd0, 4'd0);
         total++;
         if ({dig_en, seg, dp} !== {e_dig, e_seg, e_dp}) begin
            bad++;
            $display("FAIL restart_run i=%0d got %b/%h/%b want %b/%h/%b",
                     i, dig_en, seg, dp, e_dig, e_seg, e_dp);
         end
      end
   endtask

   task automatic test_random;
      logic       r, l;
      logic [3:0] h, lo;
      for (int i = 0; i < 600; i++) begin
         r  = ($urandom_range(0, 99) != 0);
         l  = ($urandom_range(0, 7) == 0);
         h  = 4'($urandom_range(0, 15));
         lo = ($urandom_range(0, 2) == 0) ? h : 4'($urandom_range(0, 15));
         step(r, l, h, lo);
         total++;
         if ({dig_en, seg, dp} !== {e_dig, e_seg, e_dp}) begin
            bad++;
            $display("FAIL random i=%0d got %b/%h/%b want %b/%h/%b",
                     i, dig_en, seg, dp, e_dig, e_seg, e_dp);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_last_wins;
      test_tc_load;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
